// File: rtl/scatter_io.sv
// Tile-to-network serializer: snapshots a parallel vector and emits its first
// valid_chans words, channel 0 first, on a valid/ready stream.
`ifndef XW
`define XW 128
`endif
`ifndef QW
`define QW 16
`endif

module scatter_io #(
   parameter int unsigned valid_chans = 128
) (
   input  logic                         clk_tl,
   input  logic                         rstn_tl,
   input  logic [`XW-1:0][`QW-1:0]      tl_data_i,
   input  logic                         tl_valid_i,
   output logic                         tl_ready_o,
   output logic [`QW-1:0]               nw_data_o,
   output logic                         nw_valid_o,
   input  logic                         nw_ready_i
);

   localparam int unsigned CW = (`XW > 1) ? $clog2(`XW) : 1;
   localparam logic [CW-1:0] LAST = CW'(valid_chans - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]                         state;
   logic [CW-1:0]                      ocnt;
   logic [valid_chans-1:0][`QW-1:0]    snap;
   logic                               last_word;
   logic                               accept;
   logic                               xfer;

   assign last_word  = (ocnt == LAST);
   assign nw_valid_o = (state == SEND);
   assign tl_ready_o = (state == IDLE) | ((state == SEND) & last_word & nw_ready_i);
   assign accept     = tl_valid_i & tl_ready_o;
   assign xfer       = nw_valid_o & nw_ready_i;

   // Compare-based select keeps the index width independent of valid_chans.
   always_comb begin
      nw_data_o = '0;
      for (int unsigned i = 0; i < valid_chans; i++) begin
         if (ocnt == CW'(i)) nw_data_o = snap[i];
      end
   end

   // Accept takes priority: on the last-word transfer it reloads in place,
   // giving zero-bubble back-to-back vectors.
   always_ff @(posedge clk_tl or negedge rstn_tl) begin
      if (!rstn_tl) begin
         state <= IDLE;
         ocnt  <= '0;
         snap  <= '0;
      end else if (accept) begin
         snap  <= tl_data_i[valid_chans-1:0];
         ocnt  <= '0;
         state <= SEND;
      end else if (xfer) begin
         if (last_word) begin
            state <= IDLE;
            ocnt  <= '0;
         end else begin
            ocnt  <= ocnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_scatter_io.sv
// Randomized and directed check of scatter_io (valid_chans = 4, 1, XW) against
// a per-instance queue model of pending network words.
`ifndef XW
`define XW 128
`endif
`ifndef QW
`define QW 16
`endif

module tb_scatter_io;

   localparam int NI = 3;

   logic                      clk_tl = 1'b0;
   logic                      rstn_tl = 1'b0;
   logic [`XW-1:0][`QW-1:0]   tl_data  [NI];
   logic                      tl_valid [NI];
   logic                      tl_ready [NI];
   logic [`QW-1:0]            nw_data  [NI];
   logic                      nw_valid [NI];
   logic                      nw_ready [NI];

   logic [`QW-1:0]            pend [NI][$];
   bit                        hold [NI];
   int                        n_checks = 0;
   int                        n_errors = 0;

   always #5 clk_tl = ~clk_tl;

   scatter_io #(.valid_chans(4)) u_vc4 (
      .clk_tl(clk_tl), .rstn_tl(rstn_tl),
      .tl_data_i(tl_data[0]), .tl_valid_i(tl_valid[0]), .tl_ready_o(tl_ready[0]),
      .nw_data_o(nw_data[0]), .nw_valid_o(nw_valid[0]), .nw_ready_i(nw_ready[0]));

   scatter_io #(.valid_chans(1)) u_vc1 (
      .clk_tl(clk_tl), .rstn_tl(rstn_tl),
      .tl_data_i(tl_data[1]), .tl_valid_i(tl_valid[1]), .tl_ready_o(tl_ready[1]),
      .nw_data_o(nw_data[1]), .nw_valid_o(nw_valid[1]), .nw_ready_i(nw_ready[1]));

   scatter_io #(.valid_chans(`XW)) u_vcx (
      .clk_tl(clk_tl), .rstn_tl(rstn_tl),
      .tl_data_i(tl_data[2]), .tl_valid_i(tl_valid[2]), .tl_ready_o(tl_ready[2]),
      .nw_data_o(nw_data[2]), .nw_valid_o(nw_valid[2]), .nw_ready_i(nw_ready[2]));

   function automatic int vc_of(input int k);
      return (k == 0) ? 4 : (k == 1) ? 1 : `XW;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle_all();
      for (int k = 0; k < NI; k++) begin
         tl_valid[k] = 1'b0;
         nw_ready[k] = 1'b1;
      end
   endtask

   task automatic rand_vec(input int k);
      for (int i = 0; i < `XW; i++) tl_data[k][i] = `QW'($urandom);
   endtask

   // Called just after a negedge with inputs already driven; checks outputs
   // against the model, then advances the model across the next posedge.
   task automatic step();
      bit acc [NI];
      bit xf  [NI];
      bit ev, er;
      #2;
      for (int k = 0; k < NI; k++) begin
         ev = (pend[k].size() != 0);
         er = (pend[k].size() == 0) || (pend[k].size() == 1 && nw_ready[k]);
         chk($sformatf("d%0d nw_valid", k), 32'(nw_valid[k]), 32'(ev));
         if (ev) chk($sformatf("d%0d nw_data", k), 32'(nw_data[k]), 32'(pend[k][0]));
         chk($sformatf("d%0d tl_ready", k), 32'(tl_ready[k]), 32'(er));
         acc[k] = tl_valid[k] && er;
         xf[k]  = ev && nw_ready[k];
      end
      @(posedge clk_tl);
      for (int k = 0; k < NI; k++) begin
         if (xf[k]) void'(pend[k].pop_front());
         if (acc[k]) for (int i = 0; i < vc_of(k); i++) pend[k].push_back(tl_data[k][i]);
         hold[k] = tl_valid[k] && !acc[k];
      end
      @(negedge clk_tl);
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         tl_data[k] = '0;
         hold[k] = 1'b0;
      end
      idle_all();
      #2;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("d%0d rst nw_valid", k), 32'(nw_valid[k]), 32'd0);
         chk($sformatf("d%0d rst tl_ready", k), 32'(tl_ready[k]), 32'd1);
         chk($sformatf("d%0d rst nw_data", k), 32'(nw_data[k]), 32'd0);
      end
      @(negedge clk_tl);
      rstn_tl = 1'b1;

      // Single vector, free-flowing network.
      rand_vec(0);
      for (int i = 0; i < 4; i++) tl_data[0][i] = `QW'(8'h11 * (i + 1));
      tl_valid[0] = 1'b1;
      step();
      tl_valid[0] = 1'b0;
      repeat (6) step();

      // Back-to-back A then B: B is held until the A3 transfer cycle.
      rand_vec(0);
      tl_valid[0] = 1'b1;
      step();
      rand_vec(0);
      repeat (4) step();
      tl_valid[0] = 1'b0;
      repeat (5) step();

      // Backpressure while word 2 is presented.
      rand_vec(0);
      tl_valid[0] = 1'b1;
      step();
      tl_valid[0] = 1'b0;
      repeat (2) step();
      nw_ready[0] = 1'b0;
      repeat (3) step();
      nw_ready[0] = 1'b1;
      repeat (4) step();

      // One-word frames with tl_valid held.
      for (int v = 5; v <= 7; v++) begin
         tl_data[1][0] = `QW'(v);
         tl_valid[1] = 1'b1;
         step();
      end
      tl_valid[1] = 1'b0;
      repeat (2) step();

      // Full-width vector.
      rand_vec(2);
      tl_valid[2] = 1'b1;
      step();
      tl_valid[2] = 1'b0;
      repeat (`XW + 2) step();

      // Reset after two of four words have gone out.
      rand_vec(0);
      tl_valid[0] = 1'b1;
      step();
      tl_valid[0] = 1'b0;
      repeat (2) step();
      #3 rstn_tl = 1'b0;
      #1;
      chk("mid rst nw_valid", 32'(nw_valid[0]), 32'd0);
      chk("mid rst tl_ready", 32'(tl_ready[0]), 32'd1);
      chk("mid rst nw_data", 32'(nw_data[0]), 32'd0);
      for (int k = 0; k < NI; k++) begin
         pend[k].delete();
         hold[k] = 1'b0;
      end
      @(negedge clk_tl);
      rstn_tl = 1'b1;
      for (int i = 0; i < 4; i++) tl_data[0][i] = `QW'(16'hA0 + i);
      tl_valid[0] = 1'b1;
      step();
      tl_valid[0] = 1'b0;
      repeat (5) step();

      // Random traffic on all three instances.
      repeat (1500) begin
         for (int k = 0; k < NI; k++) begin
            nw_ready[k] = ($urandom_range(0, 3) != 0);
            if (!hold[k]) begin
               tl_valid[k] = ($urandom_range(0, 1) != 0);
               rand_vec(k);
            end
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
